// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - FSM state type and Gray/binary helper functions
package gray_pkg;

   localparam int GRAY_MAX_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRIME,
      ST_TRACK
   } gray_state_e;

   function automatic logic [GRAY_MAX_W-1:0] b2g(input logic [GRAY_MAX_W-1:0] b, input int w);
      logic [GRAY_MAX_W-1:0] g;
      g = '0;
      for (int i = 0; i < GRAY_MAX_W; i++) begin
         if (i < w) g[i] = b[i] ^ ((i + 1 < w) ? b[i+1] : 1'b0);
      end
      return g;
   endfunction

   // Each binary bit is the XOR of its Gray bit and every more-significant Gray bit.
   function automatic logic [GRAY_MAX_W-1:0] g2b(input logic [GRAY_MAX_W-1:0] g, input int w);
      logic [GRAY_MAX_W-1:0] b;
      logic                  acc;
      b   = '0;
      acc = 1'b0;
      for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
         if (i < w) begin
            acc  = acc ^ g[i];
            b[i] = acc;
         end
      end
      return b;
   endfunction

   function automatic int hamming(input logic [GRAY_MAX_W-1:0] a,
                                  input logic [GRAY_MAX_W-1:0] b,
                                  input int                    w);
      int n;
      n = 0;
      for (int i = 0; i < GRAY_MAX_W; i++) begin
         if (i < w) n += int'(a[i] ^ b[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// rtl/sync_ff_chain.sv - plain multi-stage flop synchronizer, no logic between stages
module sync_ff_chain #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stg [STAGES];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < STAGES; i++) stg[i] <= '0;
      end else begin
         stg[0] <= d_i;
         for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
      end
   end

   assign q_o = stg[STAGES-1];

endmodule

// File: rtl/gray_sync_decode.sv
// rtl/gray_sync_decode.sv - synchronizes a foreign Gray count, decodes to binary, reports delta and illegal jumps
module gray_sync_decode
   import gray_pkg::*;
#(
   parameter int VEC_W       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [VEC_W-1:0] gray_i,
   input  logic             en_i,
   input  logic             clr_err_i,
   output logic [VEC_W-1:0] bin_o,
   output logic [VEC_W-1:0] delta_o,
   output logic             bin_valid_o,
   output logic             err_o
);

   localparam int CNT_W = $clog2(SYNC_STAGES + 1);

   logic [VEC_W-1:0] gray_sync;
   logic [VEC_W-1:0] gray_q;
   logic [VEC_W-1:0] bin_next;
   logic             changed;
   logic             illegal;
   gray_state_e      state;
   logic [CNT_W-1:0] prime_cnt;

   sync_ff_chain #(
      .WIDTH  (VEC_W),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (gray_i),
      .q_o    (gray_sync)
   );

   always_comb begin
      bin_next = VEC_W'(g2b(GRAY_MAX_W'(gray_sync), VEC_W));
      changed  = (gray_sync != gray_q);
      illegal  = (hamming(GRAY_MAX_W'(gray_sync), GRAY_MAX_W'(gray_q), VEC_W) > 1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= ST_IDLE;
         prime_cnt   <= '0;
         gray_q      <= '0;
         bin_o       <= '0;
         delta_o     <= '0;
         bin_valid_o <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         bin_valid_o <= 1'b0;
         // Clear first so that a same-cycle illegal update below overrides it.
         if (clr_err_i) err_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               prime_cnt <= '0;
               if (en_i) state <= ST_PRIME;
            end
            ST_PRIME: begin
               if (!en_i) begin
                  state <= ST_IDLE;
               end else if (prime_cnt == CNT_W'(SYNC_STAGES - 1)) begin
                  // The chain now holds only post-enable samples; reload without error check.
                  gray_q <= gray_sync;
                  bin_o  <= bin_next;
                  if (bin_next != bin_o) begin
                     delta_o     <= bin_next - bin_o;
                     bin_valid_o <= 1'b1;
                  end
                  state <= ST_TRACK;
               end else begin
                  prime_cnt <= prime_cnt + CNT_W'(1);
               end
            end
            ST_TRACK: begin
               if (!en_i) begin
                  state <= ST_IDLE;
               end else if (changed) begin
                  gray_q      <= gray_sync;
                  bin_o       <= bin_next;
                  delta_o     <= bin_next - bin_o;
                  bin_valid_o <= 1'b1;
                  if (illegal) err_o <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/gray_sync_decode.md
GRAY_SYNC_DECODE -- requirements
Module: gray_sync_decode

Interface
REQ-001 The block SHALL have parameter VEC_W, default 4, giving the Gray/binary vector width (minimum 2).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth (minimum 2).
REQ-003 The block SHALL have port clk_i, input, 1 bit: single clock; all state is on its rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port gray_i, input, VEC_W bits: Gray-coded count from a foreign domain, asynchronous to clk_i.
REQ-006 The block SHALL have port en_i, input, 1 bit: tracking enable.
REQ-007 The block SHALL have port clr_err_i, input, 1 bit: clears sticky error.
REQ-008 The block SHALL have port bin_o, output, VEC_W bits: registered binary equivalent of the last accepted Gray sample.
REQ-009 The block SHALL have port delta_o, output, VEC_W bits: (new bin - previous bin) mod 2^VEC_W, valid with bin_valid_o.
REQ-010 The block SHALL have port bin_valid_o, output, 1 bit: single-cycle pulse when bin_o changes.
REQ-011 The block SHALL have port err_o, output, 1 bit: sticky flag for an illegal multi-bit Gray transition.

Function
REQ-012 gray_i SHALL pass through SYNC_STAGES flops, forming gray_sync, with no logic between stages.
REQ-013 The FSM SHALL have three states: IDLE, PRIME and TRACK.
REQ-014 IDLE SHALL go to PRIME when en_i=1; otherwise it SHALL hold.
REQ-015 PRIME SHALL count SYNC_STAGES cycles, then load gray_q<=gray_sync and bin_o<=g2b(gray_sync), and enter TRACK.
REQ-016 The PRIME exit SHALL perform no error check.
REQ-017 The PRIME exit SHALL pulse bin_valid_o, with delta_o=new-old, only if the loaded bin differs from the held bin_o.
REQ-018 In TRACK, when gray_sync != gray_q, the block SHALL update gray_q and bin_o, set delta_o=g2b(gray_sync)-bin_o (mod 2^VEC_W), and pulse bin_valid_o for one cycle.
REQ-019 In TRACK, when gray_sync == gray_q, outputs SHALL hold and bin_valid_o SHALL be 0.
REQ-020 A TRACK update whose Hamming distance between gray_sync and gray_q exceeds 1 SHALL set err_o; the update itself SHALL still occur.
REQ-021 en_i=0 in PRIME or TRACK SHALL return the FSM to IDLE next cycle; bin_o, delta_o and err_o SHALL hold and bin_valid_o SHALL be 0.
REQ-022 The synchronizer SHALL run regardless of state.
REQ-023 clr_err_i SHALL clear err_o next cycle; a same-cycle new error SHALL win (err_o stays 1).
REQ-024 Wrap-around SHALL be legal: Gray 2^(VEC_W-1) to 0 (bin max to 0) SHALL give delta_o=1 with no error.
REQ-025 Latency from a gray_i change to bin_valid_o in TRACK SHALL be SYNC_STAGES+1 cycles.
REQ-026 delta_o SHALL retain its last value when bin_valid_o=0.

Reset
REQ-027 rst_ni=0 SHALL immediately force the synchronizer flops, gray_q, bin_o, delta_o, bin_valid_o and err_o to 0, and the FSM to IDLE.
REQ-028 Reset asserted mid-operation, including mid-PRIME, SHALL discard all progress; after release the block SHALL restart from IDLE.

Structure
REQ-029 Package gray_pkg SHALL hold the FSM state enum and automatic functions b2g, g2b and hamming distance, parameterised by width.
REQ-030 The synchronizer SHALL be sub-module sync_ff_chain (params WIDTH, STAGES; ports clk_i, rst_ni, d_i, q_o).
REQ-031 No other sub-modules SHALL be used.

Verification (VEC_W=4, SYNC_STAGES=2)
REQ-032 Scenario 1: gray_i=0000, reset released, en_i=1, then after TRACK gray_i=0001 -> 3 cycles later bin_o=1, delta_o=1, bin_valid_o high exactly 1 cycle, err_o=0.
REQ-033 Scenario 2: in TRACK, gray_i stepped 1000 -> 0000 (bin 15 -> 0) -> bin_o=0, delta_o=1, err_o=0.
REQ-034 Scenario 3: in TRACK at gray 0001, gray_i jumped to 0010 -> bin_o=3, delta_o=2, bin_valid_o pulse, err_o=1 and sticky.
REQ-035 Scenario 4: clr_err_i=1 in the same cycle a new illegal jump updates -> err_o remains 1; clr_err_i alone next -> err_o=0.
REQ-036 Scenario 5: in TRACK with bin_o=2, en_i=0, then gray_i moves to 0110 (bin 4), then en_i=1 -> no pulse while disabled; at PRIME exit bin_o=4, delta_o=2, one pulse, err_o unchanged.
REQ-037 Scenario 6: rst_ni=0 during TRACK with bin_o=5 -> all outputs 0 in the same cycle; after release, PRIME runs before any pulse.
